// File: rtl/bitonic_sorter.sv
// Streaming in-word sorter: reads a run of packed words from SRAM, sorts each word's
// entries ascending through a registered bitonic network, and emits them with their source address.
module bitonic_sorter #(
    parameter int WIDTH  = 4,
    parameter int BITS   = 8,
    parameter int ADDR   = 10,
    parameter int MAXCNT = 1024,
    parameter int TYPE   = 0
) (
    input  logic                      clk_tb,
    input  logic                      rstb,
    input  logic [WIDTH*BITS-1:0]     unsorted,
    input  logic                      sort_req,
    input  logic [ADDR-1:0]           start_addr,
    input  logic [$clog2(MAXCNT):0]   data_count,
    output logic [ADDR-1:0]           read_addr,
    output logic                      read_en,
    output logic                      sort_valid,
    output logic                      sort_active,
    output logic [WIDTH*BITS-1:0]     sorted,
    output logic [ADDR-1:0]           sorted_addr
);

    localparam int LOG = $clog2(WIDTH);
    localparam int S   = LOG * (LOG + 1) / 2;
    localparam int CW  = $clog2(MAXCNT) + 1;
    localparam int WB  = WIDTH * BITS;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic            sortReqPrev_q;

    logic [S:0]      vld_q;
    logic [ADDR-1:0] pipeAddr_q [0:S];
    logic [WB-1:0]   stage_q    [0:S-1];
    logic [WB-1:0]   stageNext  [0:S-1];

    // Sign-magnitude entries are mapped to two's complement so +0 and -0 compare equal.
    function automatic logic lessThan(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [BITS-1:0] ka;
        logic [BITS-1:0] kb;
        ka = {1'b0, a[BITS-2:0]};
        kb = {1'b0, b[BITS-2:0]};
        if (a[BITS-1]) ka = -ka;
        if (b[BITS-1]) kb = -kb;
        case (TYPE)
            0:       return a < b;
            3:       return $signed(ka) < $signed(kb);
            default: return $signed(a) < $signed(b);
        endcase
    endfunction

    always_ff @(posedge clk_tb or negedge rstb) begin
        if (!rstb) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remain_q      <= '0;
            sortReqPrev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remain_q      <= remain_d;
            sortReqPrev_q <= sort_req;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        unique case (state_q)
            IDLE: begin
                if (sort_req && !sortReqPrev_q && data_count != '0) begin
                    state_d  = READ;
                    addr_d   = start_addr;
                    remain_d = data_count;
                end
            end
            READ: begin
                addr_d   = addr_q + ADDR'(1);
                remain_d = remain_q - CW'(1);
                if (remain_q == CW'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                // The job ends once the final word is on the output and nothing is behind it.
                if (vld_q[S] && vld_q[S-1:0] == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign read_en     = (state_q == READ);
    assign read_addr   = addr_q;
    assign sort_active = (state_q != IDLE);

    // Stage ST = phase p, step r; phase p merges blocks of 2^(p+1) whose direction alternates.
    for (genvar p = 0; p < LOG; p++) begin : gPhase
        for (genvar r = 0; r <= p; r++) begin : gStep
            localparam int ST   = p * (p + 1) / 2 + r;
            localparam int DIST = 1 << (p - r);
            logic [WB-1:0] src;
            if (ST == 0) begin : gFirst
                assign src = unsorted;
            end else begin : gLater
                assign src = stage_q[ST-1];
            end
            for (genvar i = 0; i < WIDTH; i++) begin : gLane
                localparam int J  = i ^ DIST;
                localparam int LO = (i < J) ? i : J;
                localparam int HI = (i < J) ? J : i;
                localparam bit UP = ((LO >> (p + 1)) & 1) == 0;
                logic swap;
                assign swap = UP ? lessThan(src[HI*BITS +: BITS], src[LO*BITS +: BITS])
                                 : lessThan(src[LO*BITS +: BITS], src[HI*BITS +: BITS]);
                assign stageNext[ST][i*BITS +: BITS] = swap ? src[J*BITS +: BITS] : src[i*BITS +: BITS];
            end
        end
    end

    // Data and address registers only load on valid so outputs hold between words.
    always_ff @(posedge clk_tb or negedge rstb) begin
        if (!rstb) begin
            vld_q <= '0;
            for (int s = 0; s <= S; s++) pipeAddr_q[s] <= '0;
            for (int s = 0; s < S; s++)  stage_q[s]    <= '0;
        end else begin
            vld_q <= {vld_q[S-1:0], read_en};
            if (read_en) pipeAddr_q[0] <= addr_q;
            for (int s = 0; s < S; s++) begin
                if (vld_q[s]) begin
                    pipeAddr_q[s+1] <= pipeAddr_q[s];
                    stage_q[s]      <= stageNext[s];
                end
            end
        end
    end

    assign sort_valid  = vld_q[S];
    assign sorted      = stage_q[S-1];
    assign sorted_addr = pipeAddr_q[S];

endmodule

// File: tb/tb_bitonic_sorter.sv
// Scoreboard bench for bitonic_sorter: three instances (unsigned, signed, sign-magnitude)
// run in lockstep from identical SRAM contents; monitors pop expected reads and outputs.
module tb_bitonic_sorter;

    localparam int WIDTH  = 4;
    localparam int BITS   = 8;
    localparam int ADDR   = 10;
    localparam int MAXCNT = 1024;
    localparam int CW     = $clog2(MAXCNT) + 1;
    localparam int WB     = WIDTH * BITS;

    typedef logic [WB-1:0] word_t;
    typedef struct { logic [ADDR-1:0] addr; int cyc; word_t w0; word_t w1; word_t w3; } outExp_t;
    typedef struct { logic [ADDR-1:0] addr; int cyc; } rdExp_t;

    logic            clk_tb = 1'b0;
    logic            rstb = 1'b0;
    logic            sort_req = 1'b0;
    logic [ADDR-1:0] start_addr = '0;
    logic [CW-1:0]   data_count = '0;

    word_t mem [0:1023];
    word_t unsorted0 = '0, unsorted1 = '0, unsorted3 = '0;
    word_t sorted0, sorted1, sorted3;
    logic [ADDR-1:0] read_addr0, read_addr1, read_addr3;
    logic [ADDR-1:0] sorted_addr0, sorted_addr1, sorted_addr3;
    logic read_en0, read_en1, read_en3;
    logic sort_valid0, sort_valid1, sort_valid3;
    logic sort_active0, sort_active1, sort_active3;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int lastFall = -1;
    logic prevActive = 1'b0;

    rdExp_t  rdQ[$];
    outExp_t outQ[$];

    always #5 clk_tb = ~clk_tb;
    always @(posedge clk_tb) cyc <= cyc + 1;

    // Single-cycle-latency SRAM read ports, one per instance.
    always @(posedge clk_tb) begin
        if (read_en0) unsorted0 <= mem[read_addr0];
        if (read_en1) unsorted1 <= mem[read_addr1];
        if (read_en3) unsorted3 <= mem[read_addr3];
    end

    bitonic_sorter #(.WIDTH(WIDTH), .BITS(BITS), .ADDR(ADDR), .MAXCNT(MAXCNT), .TYPE(0)) dut0 (
        .clk_tb(clk_tb), .rstb(rstb), .unsorted(unsorted0), .sort_req(sort_req),
        .start_addr(start_addr), .data_count(data_count), .read_addr(read_addr0),
        .read_en(read_en0), .sort_valid(sort_valid0), .sort_active(sort_active0),
        .sorted(sorted0), .sorted_addr(sorted_addr0));

    bitonic_sorter #(.WIDTH(WIDTH), .BITS(BITS), .ADDR(ADDR), .MAXCNT(MAXCNT), .TYPE(1)) dut1 (
        .clk_tb(clk_tb), .rstb(rstb), .unsorted(unsorted1), .sort_req(sort_req),
        .start_addr(start_addr), .data_count(data_count), .read_addr(read_addr1),
        .read_en(read_en1), .sort_valid(sort_valid1), .sort_active(sort_active1),
        .sorted(sorted1), .sorted_addr(sorted_addr1));

    bitonic_sorter #(.WIDTH(WIDTH), .BITS(BITS), .ADDR(ADDR), .MAXCNT(MAXCNT), .TYPE(3)) dut3 (
        .clk_tb(clk_tb), .rstb(rstb), .unsorted(unsorted3), .sort_req(sort_req),
        .start_addr(start_addr), .data_count(data_count), .read_addr(read_addr3),
        .read_en(read_en3), .sort_valid(sort_valid3), .sort_active(sort_active3),
        .sorted(sorted3), .sorted_addr(sorted_addr3));

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic noteUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=present required=none at cycle %0d", name, cyc);
    endtask

    function automatic int keyOf(input logic [BITS-1:0] v, input int ty);
        case (ty)
            0:       return int'(v);
            3:       return v[BITS-1] ? -int'(v[BITS-2:0]) : int'(v[BITS-2:0]);
            default: return int'($signed(v));
        endcase
    endfunction

    function automatic word_t refSort(input word_t w, input int ty);
        logic [BITS-1:0] e [WIDTH];
        logic [BITS-1:0] t;
        word_t res;
        for (int i = 0; i < WIDTH; i++) e[i] = w[i*BITS +: BITS];
        for (int i = 1; i < WIDTH; i++) begin
            for (int j = i; j > 0 && keyOf(e[j-1], ty) > keyOf(e[j], ty); j--) begin
                t = e[j]; e[j] = e[j-1]; e[j-1] = t;
            end
        end
        for (int i = 0; i < WIDTH; i++) res[i*BITS +: BITS] = e[i];
        return res;
    endfunction

    // Random entries avoid 0x80 so the sign-magnitude order has no +0/-0 ties.
    function automatic word_t randWord();
        word_t w;
        logic [BITS-1:0] b;
        for (int i = 0; i < WIDTH; i++) begin
            b = BITS'($urandom_range(0, 255));
            if (b == 8'h80) b = 8'h81;
            w[i*BITS +: BITS] = b;
        end
        return w;
    endfunction

    always @(negedge clk_tb) begin : mRead
        rdExp_t r;
        if (read_en0) begin
            if (rdQ.size() == 0) noteUnexpected("read_en");
            else begin
                r = rdQ.pop_front();
                checkOutput("read_addr", 64'(read_addr0), 64'(r.addr));
                checkOutput("read_cycle", 64'(cyc), 64'(r.cyc));
            end
        end
    end

    always @(negedge clk_tb) begin : mOut
        outExp_t e;
        if (sort_valid0 | sort_valid1 | sort_valid3) begin
            if (outQ.size() == 0) noteUnexpected("sort_valid");
            else begin
                e = outQ.pop_front();
                checkOutput("valid_t0", 64'(sort_valid0), 64'd1);
                checkOutput("valid_t1", 64'(sort_valid1), 64'd1);
                checkOutput("valid_t3", 64'(sort_valid3), 64'd1);
                checkOutput("out_cycle", 64'(cyc), 64'(e.cyc));
                checkOutput("sorted_addr_t0", 64'(sorted_addr0), 64'(e.addr));
                checkOutput("sorted_addr_t1", 64'(sorted_addr1), 64'(e.addr));
                checkOutput("sorted_addr_t3", 64'(sorted_addr3), 64'(e.addr));
                checkOutput("sorted_t0", 64'(sorted0), 64'(e.w0));
                checkOutput("sorted_t1", 64'(sorted1), 64'(e.w1));
                checkOutput("sorted_t3", 64'(sorted3), 64'(e.w3));
            end
        end
    end

    always @(negedge clk_tb) begin
        if (prevActive && !sort_active0) lastFall = cyc;
        prevActive = sort_active0;
    end

    // Issues one job; hand values (when hand=1) replace the model for single-word jobs.
    task automatic applyStimulus(input logic [ADDR-1:0] sa, input int cnt, input int hold,
                                 input logic hand, input word_t h0, input word_t h1, input word_t h3);
        int c;
        int waited;
        logic [ADDR-1:0] a;
        @(negedge clk_tb);
        c = cyc;
        start_addr = sa;
        data_count = CW'(cnt);
        sort_req = 1'b1;
        for (int k = 0; k < cnt; k++) begin
            a = sa + ADDR'(k);
            rdQ.push_back('{a, c + 1 + k});
            outQ.push_back('{a, c + 5 + k,
                             hand ? h0 : refSort(mem[a], 0),
                             hand ? h1 : refSort(mem[a], 1),
                             hand ? h3 : refSort(mem[a], 3)});
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_tb);
            if (cnt > 0 && i == 0) checkOutput("active_rise", 64'(sort_active0), 64'd1);
            if (cnt == 0) checkOutput("idle_active", 64'(sort_active0), 64'd0);
        end
        sort_req = 1'b0;
        if (cnt > 0) begin
            waited = 0;
            while (sort_active0 && waited < cnt + 40) begin
                @(negedge clk_tb);
                waited++;
            end
            #1;
            checkOutput("active_fall_cycle", 64'(lastFall), 64'(c + 5 + cnt));
            checkOutput("out_queue_drained", 64'(outQ.size()), 64'd0);
            checkOutput("read_queue_drained", 64'(rdQ.size()), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        for (int a = 0; a < 1024; a++) mem[a] = randWord();
        mem[5] = 32'h10FF007F;
        mem[6] = 32'h807F01FF;
        mem[7] = 32'h8302857E;

        repeat (3) @(negedge clk_tb);
        checkOutput("rst_read_en", 64'(read_en0), 64'd0);
        checkOutput("rst_read_addr", 64'(read_addr0), 64'd0);
        checkOutput("rst_sort_valid", 64'(sort_valid0), 64'd0);
        checkOutput("rst_sort_active", 64'(sort_active0), 64'd0);
        checkOutput("rst_sorted", 64'(sorted0), 64'd0);
        checkOutput("rst_sorted_addr", 64'(sorted_addr0), 64'd0);
        rstb = 1'b1;

        $display("[TB] directed single words");
        applyStimulus(10'd5, 1, 1, 1'b1, 32'hFF7F1000, 32'h7F1000FF, 32'h7F1000FF);
        applyStimulus(10'd6, 1, 1, 1'b1, 32'hFF807F01, 32'h7F01FF80, 32'h7F0180FF);
        applyStimulus(10'd7, 1, 1, 1'b1, 32'h85837E02, 32'h7E028583, 32'h7E028385);

        $display("[TB] 100-word run with sort_req held");
        applyStimulus(10'd0, 100, 20, 1'b0, '0, '0, '0);
        $display("[TB] sort_req held past end of job");
        applyStimulus(10'd300, 4, 30, 1'b0, '0, '0, '0);
        $display("[TB] address wrap");
        applyStimulus(10'd1022, 4, 1, 1'b0, '0, '0, '0);
        $display("[TB] zero count");
        applyStimulus(10'd50, 0, 10, 1'b0, '0, '0, '0);

        $display("[TB] reset mid-read");
        @(negedge clk_tb);
        c = cyc;
        start_addr = 10'd200;
        data_count = CW'(50);
        sort_req = 1'b1;
        for (int k = 0; k < 50; k++)
            rdQ.push_back('{10'(200 + k), c + 1 + k});
        for (int k = 0; k < 50; k++)
            outQ.push_back('{10'(200 + k), c + 5 + k, refSort(mem[200 + k], 0),
                             refSort(mem[200 + k], 1), refSort(mem[200 + k], 3)});
        @(negedge clk_tb);
        sort_req = 1'b0;
        repeat (5) @(negedge clk_tb);
        @(posedge clk_tb);
        #2;
        rstb = 1'b0;
        #1;
        checkOutput("midrst_read_en", 64'(read_en0), 64'd0);
        checkOutput("midrst_read_addr", 64'(read_addr0), 64'd0);
        checkOutput("midrst_sort_valid", 64'(sort_valid0), 64'd0);
        checkOutput("midrst_sort_active", 64'(sort_active0), 64'd0);
        checkOutput("midrst_sorted", 64'(sorted0), 64'd0);
        checkOutput("midrst_sorted_addr", 64'(sorted_addr0), 64'd0);
        checkOutput("midrst_active_t1", 64'(sort_active1), 64'd0);
        checkOutput("midrst_active_t3", 64'(sort_active3), 64'd0);
        rdQ.delete();
        outQ.delete();
        repeat (2) @(negedge clk_tb);
        rstb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_tb);
            checkOutput("postrst_valid", 64'(sort_valid0), 64'd0);
            checkOutput("postrst_active", 64'(sort_active0), 64'd0);
        end
        applyStimulus(10'd40, 3, 1, 1'b0, '0, '0, '0);

        repeat (5) @(negedge clk_tb);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
